// File: rtl/mcast_repl_sched.sv
// Multicast replication scheduler: holds one flit and presents a copy to every
// port in its destination mask until each port has taken it.
module mcast_repl_sched #(
    parameter int FLIT_W   = 64,
    parameter int NPORTS   = 5,
    parameter int FLAG_BIT = 31,
    parameter int MASK_LSB = 26
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        in_flit,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [FLIT_W*NPORTS-1:0] out_flit_flat,
    output logic [NPORTS-1:0]        out_valid_flat,
    input  logic [NPORTS-1:0]        out_ready_flat,
    output logic                     busy,
    output logic                     mask_err,
    output logic [7:0]               stall_cnt
);

    typedef enum logic {IDLE, REPL} state_t;

    state_t              state_p1, state_d;
    logic [NPORTS-1:0]   mask_in;
    logic [NPORTS-1:0]   pending_p1;
    logic [NPORTS-1:0]   dlv;
    logic [FLIT_W-1:0]   hold_p1;
    logic                mask_err_p1;
    logic [7:0]          stall_p1;
    logic                accept;

    function automatic logic [FLIT_W-1:0] clear_flag(input logic [FLIT_W-1:0] f);
        logic [FLIT_W-1:0] r;
        r           = f;
        r[FLAG_BIT] = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign mask_in        = in_flit[MASK_LSB +: NPORTS];
    assign in_ready       = (state_p1 == IDLE);
    assign busy           = (state_p1 == REPL);
    assign accept         = in_valid && in_ready;
    // Non-pending ports' ready bits are masked off here.
    assign dlv            = (state_p1 == REPL) ? (pending_p1 & out_ready_flat) : '0;
    assign out_valid_flat = (state_p1 == REPL) ? pending_p1 : '0;
    assign out_flit_flat  = {NPORTS{hold_p1}};
    assign mask_err       = mask_err_p1;
    assign stall_cnt      = stall_p1;

    always_ff @(posedge clk) begin
        if (rst) state_p1 <= IDLE;
        else     state_p1 <= state_d;
    end

    always_comb begin
        state_d = state_p1;
        case (state_p1)
            IDLE:    if (accept && (|mask_in)) state_d = REPL;
            REPL:    if ((pending_p1 & ~dlv) == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: hold register, pending copies, error pulse and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_p1  <= '0;
            hold_p1     <= '0;
            mask_err_p1 <= 1'b0;
            stall_p1    <= 8'd0;
        end else begin
            mask_err_p1 <= accept && (mask_in == '0);
            if (state_p1 == IDLE) begin
                if (accept && (|mask_in)) begin
                    hold_p1    <= clear_flag(in_flit);
                    pending_p1 <= mask_in;
                    stall_p1   <= 8'd0;
                end
            end else begin
                pending_p1 <= pending_p1 & ~dlv;
                stall_p1   <= (|dlv) ? 8'd0 : sat_inc8(stall_p1);
            end
        end
    end

endmodule
